verdict_stream_packer: RTL and testbench
========================================

// Module: verdict_stream_packer
// PURPOSE
//   Downstream stage of the RTLola monitor topEntity. Captures every cycle in which
//   any of the four monitor outputs is active: a 64-bit timestamped header plus the
//   active output values. Buffers these frames in a FIFO and streams them out as
//   64-bit words over a valid/ready link to the host/trace interface.
//   Frames that arrive while the FIFO is full are dropped and counted.
// PARAMETERS
//   DEPTH   8    FIFO depth in frames; power of two, >= 2
//   TS_W    48   timestamp counter width; 1..48, zero-extended into the header
// PORTS
//   clk            in   1   system clock, rising edge
//   rst            in   1   asynchronous reset, active-low
//   en             in   1   global enable; gates capture and the timestamp counter only
//   output_k       in   64  monitor output value, k = 0..3, signed
//   output_k_aktv  in   1   output_k active this cycle, k = 0..3
//   m_data         out  64  stream word
//   m_valid        out  1   m_data valid
//   m_ready        in   1   consumer accepts the word; transfer when m_valid & m_ready
//   m_last         out  1   last word of the current frame
//   ovf_clr        in   1   one-cycle pulse; clears overflow and drop_count
//   overflow       out  1   sticky: at least one frame was dropped
//   drop_count     out  16  dropped frames, saturates at 16'hFFFF
//   fifo_level     out  $clog2(DEPTH)+1   frames currently held in the FIFO
// BEHAVIOUR
//   Reset: asserting rst=0 takes effect immediately.
//     - m_valid, m_last, m_data, overflow, drop_count, fifo_level all go to 0.
//     - ts, seq and FIFO pointers are cleared; FSM goes to IDLE.
//     - A frame in flight is abandoned; no partial frame resumes after reset.
//   Timestamp ts: increments by 1 every clk with en=1; wraps at 2^TS_W; frozen when en=0.
//   Capture: in a cycle with en=1 and any aktv=1, one frame is formed:
//     - frame = {ts (pre-increment value), seq, mask = {aktv3..aktv0}, value0..value3}.
//     - FIFO not full at the start of the cycle: write at the clock edge, seq += 1 (12-bit, wraps).
//     - FIFO full: the frame is dropped, even if the FSM pops in the same cycle.
//       overflow is set to 1; drop_count increments (saturating); seq is unchanged.
//   ovf_clr together with a drop in the same cycle: overflow=1, drop_count=1.
//   Header word layout:
//     - [63:16] = ts, zero-extended to 48 bits.
//     - [15:4]  = seq.
//     - [3:0]   = mask.
//   FSM:
//     - IDLE: if the FIFO is non-empty, pop into the shadow register and go to HDR.
//     - HDR: m_valid=1, m_data=header, m_last=0. On transfer, go to DATA with
//       idx = lowest set bit of mask.
//     - DATA: m_data=value[idx]; m_last=1 when idx is the highest set bit of mask.
//       On transfer, idx moves to the next set bit; after the last word, go to IDLE.
//   Frame length is 1 + popcount(mask) words (2..5).
//   Latency: capture in cycle N -> header valid in cycle N+2 when the FIFO was empty
//     and the FSM was in IDLE.
//   Inter-frame gap: exactly one cycle (IDLE) between consecutive frames.
//   Stability: while m_valid=1 and m_ready=0, m_data and m_last hold stable.
//   Backpressure never stalls capture; buffering is DEPTH frames plus one in the shadow register.
//   fifo_level excludes the frame held in the shadow register.
// TESTING
//   1. Reset, then aktv=4'b0011, out0=1, out1=1 with ts=500, m_ready=1:
//      -> words hdr{ts=500,seq=0,mask=3}, 1, 1(m_last); frame starts 2 cycles after capture.
//   2. Single aktv2, out2=-7:
//      -> 2 words; word1 = 64'hFFFF_FFFF_FFFF_FFF9 with m_last=1.
//   3. m_ready=0, then 10 captures, DEPTH=8:
//      -> 1 frame in shadow, fifo_level=8, 1 dropped, overflow=1, drop_count=1,
//         seq values 0..8 stream after m_ready=1.
//   4. Capture in the same cycle as ovf_clr while full:
//      -> overflow=1, drop_count=1. A later ovf_clr alone -> both 0.
//   5. rst=0 mid-frame after the header transfer:
//      -> m_valid=0 immediately; after release the next capture streams with seq=0, ts from 0.
//   6. en=0 for 20 cycles with aktv=1:
//      -> no frames; ts unchanged. Toggle m_ready randomly -> m_data stable while stalled.

Source files
------------

// File: rtl/verdict_stream_packer_if.sv
// rtl/verdict_stream_packer_if.sv - 64-bit verdict stream link between packer and host/trace sink
interface verdict_stream_packer_if;
    logic [63:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/verdict_stream_packer.sv
// rtl/verdict_stream_packer.sv - captures active monitor outputs as timestamped frames, buffers and streams them
module verdict_stream_packer #(
    parameter int DEPTH = 8,
    parameter int TS_W  = 48
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic signed [63:0]        output_0,
    input  logic signed [63:0]        output_1,
    input  logic signed [63:0]        output_2,
    input  logic signed [63:0]        output_3,
    input  logic                      output_0_aktv,
    input  logic                      output_1_aktv,
    input  logic                      output_2_aktv,
    input  logic                      output_3_aktv,
    verdict_stream_packer_if.master   strm,
    input  logic                      ovf_clr,
    output logic                      overflow,
    output logic [15:0]               drop_count,
    output logic [$clog2(DEPTH):0]    fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;

    logic [TS_W-1:0]  ts;
    logic [11:0]      seq;
    logic [63:0]      hdr_mem [DEPTH];
    logic [3:0][63:0] val_mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;

    logic [3:0]       aktv;
    logic [63:0]      hdr_in;
    logic [3:0][63:0] val_in;
    logic             capture, full, wr_en, drop, pop;

    state_t           state, state_nx;
    logic [63:0]      sh_hdr;
    logic [3:0][63:0] sh_val;
    logic [3:0]       sh_mask;
    logic [1:0]       idx, idx_nx;
    logic             last_word;

    // Lowest set bit of m at or above position from (mask is never zero here).
    function automatic logic [1:0] next_bit(input logic [3:0] m, input logic [2:0] from);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (i >= int'(from))) r = 2'(i);
        end
        return r;
    endfunction

    function automatic logic [1:0] high_bit(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    assign aktv    = {output_3_aktv, output_2_aktv, output_1_aktv, output_0_aktv};
    assign hdr_in  = {48'(ts), seq, aktv};
    assign val_in  = {output_3, output_2, output_1, output_0};
    assign capture = en && (aktv != 4'd0);
    // Fullness is judged on the level at the start of the cycle, so a same-cycle pop does not save the frame.
    assign full    = (fifo_level == LW'(DEPTH));
    assign wr_en   = capture && !full;
    assign drop    = capture && full;
    assign sh_mask = sh_hdr[3:0];

    always_comb begin
        state_nx     = state;
        idx_nx       = idx;
        pop          = 1'b0;
        last_word    = 1'b0;
        strm.m_valid = 1'b0;
        strm.m_data  = 64'd0;
        strm.m_last  = 1'b0;
        case (state)
            S_IDLE: begin
                if (fifo_level != '0) begin
                    pop      = 1'b1;
                    state_nx = S_HDR;
                end
            end
            S_HDR: begin
                strm.m_valid = 1'b1;
                strm.m_data  = sh_hdr;
                if (strm.m_ready) begin
                    state_nx = S_DATA;
                    idx_nx   = next_bit(sh_mask, 3'd0);
                end
            end
            S_DATA: begin
                last_word    = (idx == high_bit(sh_mask));
                strm.m_valid = 1'b1;
                strm.m_data  = sh_val[idx];
                strm.m_last  = last_word;
                if (strm.m_ready) begin
                    if (last_word) state_nx = S_IDLE;
                    else           idx_nx   = next_bit(sh_mask, {1'b0, idx} + 3'd1);
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            idx        <= 2'd0;
            ts         <= '0;
            seq        <= 12'd0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            sh_hdr     <= 64'd0;
            sh_val     <= '0;
            overflow   <= 1'b0;
            drop_count <= 16'd0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            if (en) ts <= ts + TS_W'(1);
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
                seq    <= seq + 12'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                sh_hdr <= hdr_mem[rd_ptr];
                sh_val <= val_mem[rd_ptr];
            end
            fifo_level <= fifo_level + LW'(wr_en) - LW'(pop);
            // A drop wins over a simultaneous clear: the new drop is the only one counted.
            if (drop) begin
                overflow <= 1'b1;
                if (ovf_clr)                     drop_count <= 16'd1;
                else if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end else if (ovf_clr) begin
                overflow   <= 1'b0;
                drop_count <= 16'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            hdr_mem[wr_ptr] <= hdr_in;
            val_mem[wr_ptr] <= val_in;
        end
    end
endmodule

// File: tb/tb_verdict_stream_packer.sv
// tb/tb_verdict_stream_packer.sv - directed bench for verdict_stream_packer
module tb_verdict_stream_packer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, en, ovf_clr;
    logic signed [63:0] o0, o1, o2, o3;
    logic [3:0]         aktv;
    logic               overflow;
    logic [15:0]        drop_count;
    logic [3:0]         fifo_level;

    verdict_stream_packer_if sif();

    verdict_stream_packer #(.DEPTH(8), .TS_W(48)) dut (
        .clk(clk), .rst(rst), .en(en),
        .output_0(o0), .output_1(o1), .output_2(o2), .output_3(o3),
        .output_0_aktv(aktv[0]), .output_1_aktv(aktv[1]),
        .output_2_aktv(aktv[2]), .output_3_aktv(aktv[3]),
        .strm(sif), .ovf_clr(ovf_clr), .overflow(overflow),
        .drop_count(drop_count), .fifo_level(fifo_level)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [47:0] ts_m;
    logic [47:0] cap_ts [10];
    logic [47:0] t_cap;
    logic [63:0] exp_w [5];
    logic [63:0] hold_d;
    logic        hold_l, have_hold;
    int          k;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic e;
        e = en & rst;
        @(negedge clk);
        if (e) ts_m = ts_m + 48'd1;
    endtask

    function automatic logic [63:0] hdr(input logic [47:0] t, input logic [11:0] s, input logic [3:0] m);
        return {t, s, m};
    endfunction

    initial begin
        rst = 1'b0; en = 1'b0; ovf_clr = 1'b0; aktv = 4'd0;
        o0 = 64'sd0; o1 = 64'sd0; o2 = 64'sd0; o3 = 64'sd0;
        sif.m_ready = 1'b1;
        ts_m = 48'd0;
        #12;
        chk("rst_valid", sif.m_valid, 0);
        chk("rst_last", sif.m_last, 0);
        chk("rst_data", sif.m_data, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_level", fifo_level, 0);

        // 1: two-output frame at ts=500
        @(negedge clk);
        rst = 1'b1; en = 1'b1; ts_m = 48'd0;
        repeat (500) step();
        aktv = 4'b0011; o0 = 64'sd1; o1 = 64'sd1;
        step();
        aktv = 4'd0;
        chk("t1_n1_valid", sif.m_valid, 0);
        chk("t1_n1_level", fifo_level, 1);
        step();
        chk("t1_hdr", sif.m_data, hdr(48'd500, 12'd0, 4'b0011));
        chk("t1_hdr_valid", sif.m_valid, 1);
        chk("t1_hdr_last", sif.m_last, 0);
        step();
        chk("t1_w1", sif.m_data, 64'd1);
        chk("t1_w1_last", sif.m_last, 0);
        step();
        chk("t1_w2", sif.m_data, 64'd1);
        chk("t1_w2_last", sif.m_last, 1);
        step();
        chk("t1_idle", sif.m_valid, 0);

        // 2: single negative value on output 2
        aktv = 4'b0100; o2 = -64'sd7; t_cap = ts_m;
        step();
        aktv = 4'd0;
        step();
        chk("t2_hdr", sif.m_data, hdr(t_cap, 12'd1, 4'b0100));
        step();
        chk("t2_w1", sif.m_data, 64'hFFFF_FFFF_FFFF_FFF9);
        chk("t2_w1_last", sif.m_last, 1);
        step();
        chk("t2_idle", sif.m_valid, 0);

        // 3: stalled consumer, 10 captures into DEPTH=8
        rst = 1'b0;
        step();
        rst = 1'b1; ts_m = 48'd0; sif.m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            aktv = 4'b1001; o0 = 64'(i); o3 = 64'(100 + i); cap_ts[i] = ts_m;
            step();
        end
        aktv = 4'd0;
        chk("t3_level", fifo_level, 8);
        chk("t3_ovf", overflow, 1);
        chk("t3_drop", drop_count, 1);
        chk("t3_stall_hdr", sif.m_data, hdr(cap_ts[0], 12'd0, 4'b1001));
        sif.m_ready = 1'b1;
        for (int f = 0; f < 9; f++) begin
            chk("t3_hdr", sif.m_data, hdr(cap_ts[f], 12'(f), 4'b1001));
            chk("t3_hdr_valid", sif.m_valid, 1);
            step();
            chk("t3_v0", sif.m_data, 64'(f));
            chk("t3_v0_last", sif.m_last, 0);
            step();
            chk("t3_v3", sif.m_data, 64'(100 + f));
            chk("t3_v3_last", sif.m_last, 1);
            step();
            chk("t3_gap", sif.m_valid, 0);
            step();
        end
        chk("t3_drained", fifo_level, 0);

        // 4: drop coinciding with ovf_clr
        sif.m_ready = 1'b0;
        t_cap = ts_m;
        for (int i = 0; i < 9; i++) begin
            aktv = 4'b0001; o0 = 64'(i);
            step();
        end
        chk("t4_level", fifo_level, 8);
        step();
        chk("t4_drop2", drop_count, 2);
        ovf_clr = 1'b1;
        step();
        aktv = 4'd0;
        chk("t4_clr_drop_ovf", overflow, 1);
        chk("t4_clr_drop_cnt", drop_count, 1);
        step();
        ovf_clr = 1'b0;
        chk("t4_clr_ovf", overflow, 0);
        chk("t4_clr_cnt", drop_count, 0);
        chk("t4_level_kept", fifo_level, 8);

        // 5: reset after the header of a frame has transferred
        chk("t5_hdr", sif.m_data, hdr(t_cap, 12'd9, 4'b0001));
        sif.m_ready = 1'b1;
        step();
        chk("t5_mid_valid", sif.m_valid, 1);
        chk("t5_mid_data", sif.m_data, 64'd0);
        rst = 1'b0;
        #1;
        chk("t5_rst_valid", sif.m_valid, 0);
        chk("t5_rst_data", sif.m_data, 0);
        chk("t5_rst_level", fifo_level, 0);
        chk("t5_rst_ovf", overflow, 0);
        @(negedge clk);
        rst = 1'b1; ts_m = 48'd0;
        aktv = 4'b0010; o1 = 64'sd42;
        step();
        aktv = 4'd0;
        chk("t5_n1_valid", sif.m_valid, 0);
        step();
        chk("t5_hdr_fresh", sif.m_data, hdr(48'd0, 12'd0, 4'b0010));
        step();
        chk("t5_w1", sif.m_data, 64'd42);
        chk("t5_w1_last", sif.m_last, 1);
        step();

        // 6: en=0 freezes capture and ts; random backpressure
        t_cap = ts_m;
        en = 1'b0; aktv = 4'b0001; o0 = 64'sd7;
        repeat (20) step();
        chk("t6_no_frames_level", fifo_level, 0);
        chk("t6_no_frames_valid", sif.m_valid, 0);
        en = 1'b1; aktv = 4'b1111;
        o0 = 64'sd11; o1 = 64'sd22; o2 = 64'sd33; o3 = -64'sd44;
        step();
        aktv = 4'd0;
        exp_w[0] = hdr(t_cap, 12'd1, 4'b1111);
        exp_w[1] = 64'd11;
        exp_w[2] = 64'd22;
        exp_w[3] = 64'd33;
        exp_w[4] = 64'hFFFF_FFFF_FFFF_FFD4;
        k = 0; have_hold = 1'b0; hold_d = 64'd0; hold_l = 1'b0;
        for (int c = 0; c < 200 && k < 5; c++) begin
            if (have_hold) begin
                chk("t6_stable_data", sif.m_data, hold_d);
                chk("t6_stable_last", sif.m_last, hold_l);
            end
            have_hold = 1'b0;
            sif.m_ready = (c < 3) ? 1'b0 : 1'($urandom_range(0, 1));
            if (sif.m_valid) begin
                if (sif.m_ready) begin
                    chk("t6_word", sif.m_data, exp_w[k]);
                    chk("t6_last", sif.m_last, (k == 4) ? 64'd1 : 64'd0);
                    k++;
                end else begin
                    hold_d = sif.m_data; hold_l = sif.m_last; have_hold = 1'b1;
                end
            end
            step();
        end
        chk("t6_all_words", k, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
